// File: rtl/i2c_master_byte_ctrl_if.sv
// Command, status and open-drain pad bundle of the byte-level I2C master.
// master: controller side; slave: front end plus bus side.
interface i2c_master_byte_ctrl_if #(
    parameter int PRESCALE_W = 16
);
    logic [PRESCALE_W-1:0] prescale;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_start;
    logic                  cmd_stop;
    logic                  cmd_write;
    logic                  cmd_read;
    logic [7:0]            tx_data;
    logic                  ack_in;
    logic [7:0]            rx_data;
    logic                  ack_out;
    logic                  done;
    logic                  busy;
    logic                  arb_lost;
    logic                  scl_i;
    logic                  sda_i;
    logic                  scl_o;
    logic                  sda_o;
    logic                  scl_oen;
    logic                  sda_oen;

    modport master (
        input  prescale, cmd_valid, cmd_start, cmd_stop,
        input  cmd_write, cmd_read, tx_data, ack_in,
        input  scl_i, sda_i,
        output cmd_ready, rx_data, ack_out, done, busy, arb_lost,
        output scl_o, sda_o, scl_oen, sda_oen
    );

    modport slave (
        output prescale, cmd_valid, cmd_start, cmd_stop,
        output cmd_write, cmd_read, tx_data, ack_in,
        output scl_i, sda_i,
        input  cmd_ready, rx_data, ack_out, done, busy, arb_lost,
        input  scl_o, sda_o, scl_oen, sda_oen
    );
endinterface

// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C master: START / one byte / STOP sequencing in four
// quarters per bus phase, with clock stretching and arbitration loss.
module i2c_master_byte_ctrl #(
    parameter int PRESCALE_W = 16
) (
    input  logic                   pclk,
    input  logic                   areset,
    i2c_master_byte_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BYTE, S_STOP, S_DONE
    } state_t;

    localparam logic [PRESCALE_W-1:0] ONE = 1;

    state_t                r_state;
    logic [PRESCALE_W-1:0] r_pre;
    logic [PRESCALE_W-1:0] r_qcnt;
    logic [1:0]            r_q;
    logic [3:0]            r_bit;
    logic                  r_stop;
    logic                  r_wr;
    logic                  r_rd;
    logic                  r_ack_in;
    logic [7:0]            r_tx;
    logic [7:0]            r_sh;
    logic [7:0]            r_rx;
    logic                  r_scl_oen;
    logic                  r_sda_oen;
    logic                  r_done;
    logic                  r_arb;
    logic                  r_ack_out;

    logic   w_idle;
    logic   w_phase;
    logic   w_hold;
    logic   w_tick;
    logic   w_arb;
    logic   w_b;
    logic   w_p;
    logic   w_drv0;
    logic   w_ent_scl;
    logic   w_ent_sda;
    state_t w_nxt;

    // SDA drive enable for bit b: data bits on write, master ACK on read
    function automatic logic f_drv(input logic [3:0] b, input logic wr,
                                   input logic ack, input logic [7:0] tx);
        if (b == 4'd8) return !wr && !ack;
        return wr && !tx[3'd7 - b[2:0]];
    endfunction

    assign w_idle  = (r_state == S_IDLE);
    assign w_phase = (r_state == S_START) || (r_state == S_BYTE) ||
                     (r_state == S_STOP);
    assign w_hold  = w_phase && (r_q == 2'd1 || r_q == 2'd2) && !bus.scl_i;
    assign w_tick  = (r_qcnt == r_pre) && !w_hold;
    assign w_arb   = !bus.sda_i && !r_sda_oen && (
        (r_state == S_START && (r_q == 2'd1 || r_q == 2'd2)) ||
        (r_state == S_BYTE && r_wr && r_bit != 4'd8 &&
         r_q == 2'd2 && w_tick));

    always_comb begin
        w_b = w_idle ? (bus.cmd_write | bus.cmd_read) : (r_wr | r_rd);
        w_p = w_idle ? bus.cmd_stop : r_stop;
        w_drv0 = w_idle ?
            f_drv(4'd0, bus.cmd_write, bus.ack_in, bus.tx_data) :
            f_drv(4'd0, r_wr, r_ack_in, r_tx);
        w_nxt = S_DONE;
        if (w_idle && bus.cmd_start)
            w_nxt = S_START;
        else if ((w_idle || r_state == S_START) && w_b)
            w_nxt = S_BYTE;
        else if (r_state != S_STOP && w_p)
            w_nxt = S_STOP;
        w_ent_scl = r_scl_oen;
        w_ent_sda = r_sda_oen;
        case (w_nxt)
            S_START: w_ent_sda = 1'b0;
            S_BYTE: begin
                w_ent_scl = 1'b1;
                w_ent_sda = w_drv0;
            end
            S_STOP: begin
                w_ent_scl = 1'b1;
                w_ent_sda = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            r_state   <= S_IDLE;
            r_pre     <= '0;
            r_qcnt    <= '0;
            r_q       <= 2'd0;
            r_bit     <= 4'd0;
            r_stop    <= 1'b0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_ack_in  <= 1'b0;
            r_tx      <= 8'h00;
            r_sh      <= 8'h00;
            r_rx      <= 8'h00;
            r_scl_oen <= 1'b0;
            r_sda_oen <= 1'b0;
            r_done    <= 1'b0;
            r_arb     <= 1'b0;
            r_ack_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_arb  <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.cmd_valid) begin
                    r_pre     <= bus.prescale;
                    r_stop    <= bus.cmd_stop;
                    r_wr      <= bus.cmd_write;
                    r_rd      <= bus.cmd_read;
                    r_tx      <= bus.tx_data;
                    r_ack_in  <= bus.ack_in;
                    r_qcnt    <= '0;
                    r_q       <= 2'd0;
                    r_bit     <= 4'd0;
                    r_state   <= w_nxt;
                    r_scl_oen <= w_ent_scl;
                    r_sda_oen <= w_ent_sda;
                    r_done    <= (w_nxt == S_DONE);
                end
                S_DONE: r_state <= S_IDLE;
                default: begin
                    if (w_arb) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_arb     <= 1'b1;
                        r_scl_oen <= 1'b0;
                        r_sda_oen <= 1'b0;
                    end else if (w_tick) begin
                        r_qcnt <= '0;
                        r_q    <= r_q + 2'd1;
                        if (r_state == S_BYTE && r_q == 2'd2) begin
                            if (r_bit == 4'd8) begin
                                if (r_wr) r_ack_out <= bus.sda_i;
                            end else if (!r_wr) begin
                                r_sh <= {r_sh[6:0], bus.sda_i};
                                if (r_bit == 4'd7)
                                    r_rx <= {r_sh[6:0], bus.sda_i};
                            end
                        end
                        if (r_q == 2'd0) r_scl_oen <= 1'b0;
                        if (r_q == 2'd1 && r_state == S_START)
                            r_sda_oen <= 1'b1;
                        if (r_q == 2'd2) begin
                            if (r_state == S_STOP) r_sda_oen <= 1'b0;
                            else                   r_scl_oen <= 1'b1;
                        end
                        if (r_q == 2'd3) begin
                            if (r_state == S_BYTE && r_bit != 4'd8) begin
                                r_bit     <= r_bit + 4'd1;
                                r_sda_oen <= f_drv(r_bit + 4'd1, r_wr,
                                                   r_ack_in, r_tx);
                            end else begin
                                r_state   <= w_nxt;
                                r_bit     <= 4'd0;
                                r_scl_oen <= w_ent_scl;
                                r_sda_oen <= w_ent_sda;
                                r_done    <= (w_nxt == S_DONE);
                            end
                        end
                    end else if (!w_hold) begin
                        r_qcnt <= r_qcnt + ONE;
                    end
                end
            endcase
        end
    end

    assign bus.cmd_ready = w_idle;
    assign bus.busy      = !w_idle;
    assign bus.done      = r_done;
    assign bus.arb_lost  = r_arb;
    assign bus.rx_data   = r_rx;
    assign bus.ack_out   = r_ack_out;
    assign bus.scl_o     = 1'b0;
    assign bus.sda_o     = 1'b0;
    assign bus.scl_oen   = r_scl_oen;
    assign bus.sda_oen   = r_sda_oen;
endmodule

// File: doc/i2c_master_byte_ctrl.md
# i2c_master_byte_ctrl

Byte-level I2C master controller that sequences the open-drain SCL/SDA pads of the I2C interface. It accepts one command at a time: optional START, one byte write or read, optional STOP. It generates bus timing from a programmable prescaler, honours slave clock stretching and detects lost arbitration. It sits between a register/sequencer front end and the pad-level `scl_*`/`sda_*` signals of the interface.

## Interface
- `PRESCALE_W`, 16: width of the `prescale` input.
- `pclk` input 1: system clock. All logic is on its rising edge.
- `areset` input 1: asynchronous, active-low reset.
- `prescale` input PRESCALE_W: quarter-bit period minus 1, in pclk cycles. Latched when a command is accepted.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: high only in IDLE. A command is accepted on a cycle where `cmd_valid` and `cmd_ready` are both high.
- `cmd_start`, `cmd_stop`, `cmd_write`, `cmd_read` input 1 each: command fields, sampled at accept.
- `tx_data` input 8: byte to write, sampled at accept.
- `ack_in` input 1: acknowledge the master sends after a read. 0 = ACK, 1 = NACK. Sampled at accept.
- `rx_data` output 8: byte read from the bus. Valid when `done` is high; held until the next read completes.
- `ack_out` output 1: acknowledge sampled after a write. 0 = ACK.
- `done` output 1: one-cycle pulse when a command finishes or is aborted.
- `busy` output 1: high from the cycle after accept until the cycle `done` is high, inclusive.
- `arb_lost` output 1: one-cycle pulse, coincident with `done`, when arbitration is lost.
- `scl_i`, `sda_i` input 1: resolved bus levels.
- `scl_o`, `sda_o` output 1: tied to 0. The bus is open-drain.
- `scl_oen`, `sda_oen` output 1: 1 drives the line low; 0 releases it to the pull-up.

## Operation
- Reset values: `scl_oen`, `sda_oen`, `done`, `busy`, `arb_lost`, `ack_out` = 0; `rx_data` = 8'h00; `cmd_ready` = 1; state IDLE.
- Reset is asynchronous. Asserting it mid-transfer releases both lines immediately and discards the command.
- States and order: IDLE -> START (if `cmd_start`) -> BYTE (if `cmd_write` or `cmd_read`) -> STOP (if `cmd_stop`) -> DONE -> IDLE. Phases whose bit is clear are skipped.
- Field corner cases:
  - `cmd_write` and `cmd_read` both set: execute a write.
  - All four fields clear: go straight to DONE. No bus activity.
- Every bus phase is split into four quarters, Q0 to Q3. Each quarter lasts `prescale`+1 pclk cycles.
- START (also used for a repeated START):
  - Q0: release SDA.
  - Q1: release SCL.
  - Q2: drive SDA low.
  - Q3: drive SCL low.
- BYTE has 9 bits: 8 data bits MSB first, then the ACK bit. Per bit:
  - Q0: SCL low; set SDA.
  - Q1: release SCL.
  - Q2: SCL high; sample `sda_i` on the last cycle of Q2.
  - Q3: drive SCL low.
- SDA level per bit:
  - Write data bits: `tx_data` bit (1 = release).
  - Write ACK bit: release; the sample goes to `ack_out`.
  - Read data bits: release; samples shift into `rx_data`.
  - Read ACK bit: drive `ack_in`.
- STOP:
  - Q0: SCL low, SDA low.
  - Q1: release SCL.
  - Q2: SDA stays low.
  - Q3: release SDA.
- Without STOP, the controller ends with SCL held low (bus owned) and SDA as last driven.
- Clock stretching: in Q1 and Q2 of START, BYTE and STOP, the quarter counter holds while `scl_i` is 0. It resumes counting from where it stopped once `scl_i` is 1.
- Arbitration loss:
  - Trigger: the controller has released SDA for a write data bit or for START Q1/Q2, and `sda_i` is sampled 0.
  - Response: release both lines next cycle, pulse `arb_lost` and `done`, return to IDLE.
  - Checked at the Q2 sample point of bits, and on every cycle of START Q1 and Q2.

## Timing
- Quarter length: `prescale`+1 cycles. `prescale`=0 is legal (1-cycle quarters).
- With no stretching:
  - START = 4 quarters.
  - BYTE = 36 quarters.
  - STOP = 4 quarters.
  - `done` rises 1 cycle after the final quarter ends.
- Example: START+write+STOP at `prescale`=4 runs 44 quarters = 220 cycles from the cycle after accept. `done` pulses at cycle 221.
- `cmd_ready` goes low the cycle after accept. It returns high the cycle after `done`.
- `busy` is high from the cycle after accept through the `done` cycle.
- Outputs are registered. Pad enables change exactly on quarter boundaries.

## Test plan
- START+write 8'hA5+STOP, `prescale`=4, slave ACKs:
  - SDA pattern on SCL rising edges is 1,0,1,0,0,1,0,1.
  - `ack_out`=0.
  - `done` pulses at cycle 221.
  - Both lines released at the end.
- START+read+STOP, `ack_in`=1, slave drives 8'h3C:
  - `rx_data`=8'h3C.
  - Master releases SDA in the ACK bit.
  - STOP observed (SDA rises while SCL is high).
- Slave holds `scl_i` low for 50 cycles in Q1 of bit 3:
  - Total time grows by exactly 50 cycles.
  - No bit is lost.
- Write 8'hFF with an external agent pulling `sda_i` low at bit 2:
  - `arb_lost`=1 and `done`=1 in the same cycle.
  - `scl_oen`=`sda_oen`=0 the next cycle; state IDLE.
- Back-to-back commands START+write, then START+write+STOP:
  - Repeated START occurs: SDA falls while SCL is high, without a STOP between.
  - SCL stays low between the two commands.
- Assert `areset` during bit 5 of a write:
  - `scl_oen`=`sda_oen`=0 immediately.
  - `cmd_ready`=1 after release of reset.
  - `done` is never pulsed.
